// File: rtl/operand_skew_feeder.sv
`default_nettype none
// ============================================================================
// operand_skew_feeder : ping-pong tile buffer driving a diagonally skewed
//                       wavefront onto the systolic array edge lanes.
// Revision 1.0
// ============================================================================
module operand_skew_feeder #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [N*W-1:0] in_row_i,
  output logic [N*W-1:0] a_data_o,
  output logic [N-1:0]   lane_valid_o,
  output logic           done_o,
  output logic           busy_o
);

  localparam int TW = $clog2(2*N-1);
  localparam int RW = $clog2(N);
  localparam logic [TW-1:0] LAST_T   = TW'(2*N-2);
  localparam logic [RW-1:0] LAST_ROW = RW'(N-1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     t_q, t_d, t_inc;
  logic [1:0]        full_q, full_d;
  logic              wbank_q, rbank_q, rbank_d;
  logic [RW-1:0]     wrow_q;
  logic              chain_q, chain_d;
  logic              done_q, done_d;
  logic [N*W-1:0]    a_data_q;
  logic [N-1:0]      lane_valid_q;

  logic              hs;
  logic              clr_full;
  logic              beat_en;
  logic [TW-1:0]     beat_t;
  logic [N-1:0]      lane_hit;
  logic [N*W-1:0]    lane_data;

  logic [N-1:0][W-1:0] mem_q [2][N];

  assign in_ready_o   = ~full_q[wbank_q];
  assign hs           = in_valid_i & in_ready_o;
  assign t_inc        = t_q + 1'b1;
  assign busy_o       = (state_q == S_STREAM);
  assign a_data_o     = a_data_q;
  assign lane_valid_o = lane_valid_q;
  assign done_o       = done_q;

  // Tile storage needs no reset: a bank is only read once its full flag is set.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      mem_q[wbank_q][wrow_q] <= in_row_i;
    end
  end

  always_comb begin
    full_d = full_q;
    if (hs && (wrow_q == LAST_ROW)) begin
      full_d[wbank_q] = 1'b1;
    end
    if (clr_full) begin
      full_d[rbank_q] = 1'b0;
    end
  end

  // chain_q remembers whether the next tile was already complete before the
  // final beat, which decides between a seamless hand-over and a return to IDLE.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    rbank_d  = rbank_q;
    chain_d  = chain_q;
    done_d   = 1'b0;
    clr_full = 1'b0;
    beat_en  = 1'b0;
    beat_t   = '0;
    case (state_q)
      S_IDLE: begin
        if (full_q[rbank_q]) begin
          state_d = S_STREAM;
          t_d     = '0;
          beat_en = 1'b1;
        end
      end
      S_STREAM: begin
        if (t_q == LAST_T) begin
          chain_d = 1'b0;
          t_d     = '0;
          if (chain_q) begin
            beat_en = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          t_d     = t_inc;
          beat_t  = t_inc;
          beat_en = 1'b1;
          if (t_inc == LAST_T) begin
            clr_full = 1'b1;
            rbank_d  = ~rbank_q;
            done_d   = 1'b1;
            chain_d  = full_q[~rbank_q];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // k wraps to a value >= N when beat_t < lane, so one compare covers both bounds.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    localparam logic [TW-1:0] LANE = TW'(gi);
    logic [TW-1:0] k;
    assign k = beat_t - LANE;
    assign lane_hit[gi] = beat_en && (k < TW'(N));
    assign lane_data[gi*W +: W] = lane_hit[gi] ? mem_q[rbank_q][gi][k[RW-1:0]] : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      full_q       <= '0;
      wbank_q      <= 1'b0;
      rbank_q      <= 1'b0;
      wrow_q       <= '0;
      chain_q      <= 1'b0;
      done_q       <= 1'b0;
      a_data_q     <= '0;
      lane_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      full_q       <= full_d;
      rbank_q      <= rbank_d;
      chain_q      <= chain_d;
      done_q       <= done_d;
      a_data_q     <= lane_data;
      lane_valid_q <= lane_hit;
      if (hs) begin
        if (wrow_q == LAST_ROW) begin
          wrow_q  <= '0;
          wbank_q <= ~wbank_q;
        end else begin
          wrow_q  <= wrow_q + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_skew_feeder.sv
`default_nettype none
// ============================================================================
// tb_operand_skew_feeder : scoreboard bench for the skewed tile feeder.
// Revision 1.0
// ============================================================================
module tb_operand_skew_feeder;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int NB = 2*N-1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic [N*W-1:0] in_row = '0;
  logic           in_ready_o;
  logic [N*W-1:0] a_data_o;
  logic [N-1:0]   lane_valid_o;
  logic           done_o;
  logic           busy_o;

  operand_skew_feeder #(.N(N), .W(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready_o),
    .in_row_i     (in_row),
    .a_data_o     (a_data_o),
    .lane_valid_o (lane_valid_o),
    .done_o       (done_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             c;
    logic [N*W-1:0] d;
    logic [N-1:0]   v;
    logic           dn;
  } beat_t;

  beat_t q[$];
  beat_t mon_e;
  int    n_chk  = 0;
  int    n_pass = 0;
  bit    mon_en = 1'b0;
  int    fin    = -100;

  // Hand-computed wavefront of the 0x01-based tile (rows 01-04, 11-14, 21-24, 31-34).
  logic [N*W-1:0] T1_DATA [NB] = '{32'h00000001, 32'h00001102, 32'h00211203,
                                   32'h31221304, 32'h32231400, 32'h33240000,
                                   32'h34000000};
  logic [N-1:0]   T1_VLD  [NB] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                   4'b1110, 4'b1100, 4'b1000};

  task automatic chk(input bit ok, input string what, input string detail);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", what, detail);
  endtask

  function automatic beat_t mk_beat(input logic [7:0] base, input int t, input int c);
    beat_t b;
    b.c  = c;
    b.d  = '0;
    b.v  = '0;
    b.dn = (t == NB-1);
    if (base == 8'h01) begin
      b.d = T1_DATA[t];
      b.v = T1_VLD[t];
    end else begin
      for (int i = 0; i < N; i++) begin
        if (t >= i && t <= i+N-1) begin
          b.d[i*W +: W] = base + 8'(16*i + t - i);
          b.v[i]        = 1'b1;
        end
      end
    end
    return b;
  endfunction

  // Queue the expected beats of a tile whose last row was accepted at edge last_e.
  task automatic push_tile(input logic [7:0] base, input int last_e, output int start);
    if (last_e < fin)       start = fin + 1;
    else if (last_e == fin) start = fin + 2;
    else                    start = last_e + 1;
    for (int t = 0; t < NB; t++) q.push_back(mk_beat(base, t, start + t));
    fin = start + NB - 1;
  endtask

  task automatic send_row(input logic [N*W-1:0] row, output int e);
    int w;
    bit got;
    w = 0;
    got = 1'b0;
    e = -1;
    in_row = row;
    in_valid = 1'b1;
    while (!got && w < 200) begin
      @(negedge clk);
      if (in_ready_o) begin
        got = 1'b1;
        e = cyc + 1;
      end
      @(posedge clk);
      #1;
      w++;
    end
    in_valid = 1'b0;
    if (!got) chk(1'b0, "ready_timeout", $sformatf("in_ready_o stayed 0 for %0d cycles, required 1", w));
  endtask

  task automatic send_tile(input logic [7:0] base, input int gap, output int first_e, output int last_e);
    logic [N*W-1:0] row;
    int e;
    first_e = -1;
    last_e  = -1;
    for (int r = 0; r < N; r++) begin
      if (r > 0) repeat (gap) begin @(posedge clk); #1; end
      for (int k = 0; k < N; k++) row[k*W +: W] = base + 8'(16*r + k);
      send_row(row, e);
      if (r == 0) first_e = e;
      last_e = e;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(q.size() == 0, "drain", $sformatf("%0d beats still expected, required 0", q.size()));
  endtask

  task automatic chk_idle(input string what);
    chk(a_data_o == '0 && lane_valid_o == '0 && !done_o && !busy_o && in_ready_o, what,
        $sformatf("data %h valid %b done %b busy %b ready %b, required 0/0/0/0/1",
                  a_data_o, lane_valid_o, done_o, busy_o, in_ready_o));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy_o || (lane_valid_o != '0) || done_o) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_beat", $sformatf("cycle %0d data %h valid %b, required idle",
                                                 cyc, a_data_o, lane_valid_o));
        end else begin
          mon_e = q.pop_front();
          chk(cyc == mon_e.c && a_data_o == mon_e.d && lane_valid_o == mon_e.v &&
              done_o == mon_e.dn && busy_o, "beat",
              $sformatf("got cyc %0d data %h valid %b done %b busy %b, required cyc %0d data %h valid %b done %b busy 1",
                        cyc, a_data_o, lane_valid_o, done_o, busy_o, mon_e.c, mon_e.d, mon_e.v, mon_e.dn));
        end
      end else begin
        chk(a_data_o == '0, "idle_zero", $sformatf("cycle %0d data %h, required 0", cyc, a_data_o));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe, le, st, s1, f1, w;

    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset_held");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_idle("reset_released");
    mon_en = 1'b1;

    // Single tile, back-to-back rows
    send_tile(8'h01, 0, fe, le);
    push_tile(8'h01, le, st);
    drain();

    // Back-to-back tiles: second tile loads during the first one's stream
    send_tile(8'h01, 0, fe, le);
    push_tile(8'h01, le, st);
    send_tile(8'hA0, 0, fe, le);
    push_tile(8'hA0, le, st);
    drain();

    // Backpressure: third tile waits until the first tile's final beat frees a bank
    send_tile(8'h80, 0, fe, le);
    push_tile(8'h80, le, st);
    f1 = fin;
    send_tile(8'h90, 0, fe, le);
    push_tile(8'h90, le, st);
    send_tile(8'hB0, 0, fe, le);
    chk(fe - 1 == f1, "ready_return", $sformatf("in_ready_o first high at cycle %0d, required %0d", fe - 1, f1));
    push_tile(8'hB0, le, st);
    drain();

    // Input bubbles of two cycles between rows
    send_tile(8'h01, 2, fe, le);
    push_tile(8'h01, le, st);
    drain();

    // Mid-stream reset at t = 3 with a second tile buffered
    send_tile(8'h50, 0, fe, le);
    push_tile(8'h50, le, s1);
    send_tile(8'h60, 0, fe, le);
    push_tile(8'h60, le, st);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (cyc < s1 + 3 && w < 50);
    chk(cyc == s1 + 3, "reset_point", $sformatf("reached cycle %0d, required %0d", cyc, s1 + 3));
    #2;
    rst = 1'b1;
    mon_en = 1'b0;
    #1;
    chk_idle("reset_async");
    q.delete();
    fin = -100;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset_hold");
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send_tile(8'h70, 0, fe, le);
    push_tile(8'h70, le, st);
    drain();

    chk(q.size() == 0, "queue_empty", $sformatf("%0d beats left, required 0", q.size()));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
